// File: rtl/btb_update_sched.sv
// btb_update_sched: queues branch-resolve BTB updates and slots their writes into cycles fetch leaves free
module btb_update_sched #(
    parameter int IDX_W      = 6,
    parameter int QDEPTH     = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               FetchReq,
    input  logic [31:0]        FetchAddress,
    output logic               FetchGrant,
    input  logic               ResValid,
    input  logic [31:0]        ResAddress,
    input  logic [31:0]        ResTarget,
    input  logic               ResTaken,
    input  logic               ResHit,
    input  logic [1:0]         ResBP,
    output logic               ResReady,
    output logic               BtbEn,
    output logic               BtbWe,
    output logic [IDX_W-1:0]   BtbIndex,
    output logic [29-IDX_W:0]  BtbWrTag,
    output logic [31:0]        BtbWrTarget,
    output logic [1:0]         BtbWrBP
);
    localparam int PW = $clog2(QDEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

    state_t            state_q, state_d;
    logic [PW:0]       cnt_q, cnt_d;
    logic [PW-1:0]     wp_q, rp_q;
    logic [SW-1:0]     starve_q, starve_d;
    logic              ready_q;
    logic [IDX_W-1:0]  idx_mem [QDEPTH];
    logic [29-IDX_W:0] tag_mem [QDEPTH];
    logic [31:0]       tgt_mem [QDEPTH];
    logic [1:0]        bp_mem  [QDEPTH];
    logic              enq, issue;
    logic [1:0]        new_bp;
    logic              unused;

    assign unused = ^{ResAddress[1:0], FetchAddress[31:IDX_W+2], FetchAddress[1:0]};

    // Accept filter, counter update, write-issue decision and next scheduler state
    always_comb begin
        enq      = ResValid && ready_q && (ResHit || ResTaken);
        issue    = (state_q == FORCE) || (state_q == PEND && !FetchReq);
        new_bp   = !ResHit ? 2'b10
                 : ResTaken ? (ResBP == 2'b11 ? 2'b11 : ResBP + 2'd1)
                 : (ResBP == 2'b00 ? 2'b00 : ResBP - 2'd1);
        cnt_d    = cnt_q + (PW+1)'(enq) - (PW+1)'(issue);
        starve_d = (issue || cnt_d == '0) ? '0
                 : (state_q == PEND && FetchReq && starve_q != SW'(STARVE_MAX)) ? starve_q + 1'b1
                 : starve_q;
        state_d  = cnt_d == '0 ? IDLE
                 : (cnt_d == (PW+1)'(QDEPTH) || starve_d >= SW'(STARVE_MAX)) ? FORCE
                 : PEND;
    end

    // Port mux: a queued write takes the BTB port and blocks the fetch lookup
    always_comb begin
        BtbWe       = issue;
        BtbEn       = issue || FetchReq;
        FetchGrant  = FetchReq && !issue;
        ResReady    = ready_q;
        BtbIndex    = issue ? idx_mem[rp_q] : FetchAddress[IDX_W+1:2];
        BtbWrTag    = issue ? tag_mem[rp_q] : '0;
        BtbWrTarget = issue ? tgt_mem[rp_q] : '0;
        BtbWrBP     = issue ? bp_mem[rp_q]  : '0;
    end

    // Scheduler state, occupancy and queue pointers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            starve_q <= '0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wp_q     <= wp_q + PW'(enq);
            rp_q     <= rp_q + PW'(issue);
            starve_q <= starve_d;
            ready_q  <= cnt_d < (PW+1)'(QDEPTH);
        end
    end

    // Queue payload storage; contents are don't-care while the slot is empty
    always_ff @(posedge Clk) begin
        if (enq) begin
            idx_mem[wp_q] <= ResAddress[IDX_W+1:2];
            tag_mem[wp_q] <= ResAddress[31:IDX_W+2];
            tgt_mem[wp_q] <= ResTarget;
            bp_mem[wp_q]  <= new_bp;
        end
    end
endmodule

// File: tb/tb_btb_update_sched.sv
// tb_btb_update_sched: vector tables, corner sequences and random traffic against a queue-based model
module tb_btb_update_sched;
    localparam int QD = 4;
    localparam int SM = 3;

    logic        Clk = 0, Rst = 1, FetchReq = 0, ResValid = 0, ResTaken = 0, ResHit = 0;
    logic [31:0] FetchAddress = 0, ResAddress = 0, ResTarget = 0;
    logic [1:0]  ResBP = 0;
    logic        FetchGrant, ResReady, BtbEn, BtbWe;
    logic [5:0]  BtbIndex;
    logic [23:0] BtbWrTag;
    logic [31:0] BtbWrTarget;
    logic [1:0]  BtbWrBP;

    btb_update_sched dut (
        .Clk(Clk), .Rst(Rst), .FetchReq(FetchReq), .FetchAddress(FetchAddress), .FetchGrant(FetchGrant),
        .ResValid(ResValid), .ResAddress(ResAddress), .ResTarget(ResTarget), .ResTaken(ResTaken),
        .ResHit(ResHit), .ResBP(ResBP), .ResReady(ResReady), .BtbEn(BtbEn), .BtbWe(BtbWe),
        .BtbIndex(BtbIndex), .BtbWrTag(BtbWrTag), .BtbWrTarget(BtbWrTarget), .BtbWrBP(BtbWrBP)
    );

    always #5 Clk = ~Clk;

    int checks = 0, failures = 0;

    typedef struct {
        logic [5:0]  idx;
        logic [23:0] tag;
        logic [31:0] tgt;
        logic [1:0]  bp;
    } ent_t;

    typedef struct {
        logic        hit, tk;
        logic [1:0]  bp;
        logic [31:0] pc;
        logic        exp_we;
        logic [1:0]  exp_bp;
        logic [5:0]  exp_idx;
    } vec_t;

    ent_t       mq[$];
    int         ms = 0;
    logic       o_we, o_grant, o_ready;
    logic [5:0] o_idx;
    logic [1:0] o_bp;
    logic [5:0] wlog[$];

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    function automatic logic [1:0] nbp(input logic hit, input logic tk, input logic [1:0] bp);
        int v;
        v = bp;
        if (!hit) return 2'b10;
        v = tk ? (v < 3 ? v + 1 : 3) : (v > 0 ? v - 1 : 0);
        return 2'(v);
    endfunction

    task automatic cyc(input logic fr, input logic [31:0] fa, input logic rv, input logic [31:0] ra,
                       input logic [31:0] rt, input logic tk, input logic hit, input logic [1:0] bp);
        logic fw, iss, rdy;
        ent_t e;
        FetchReq = fr; FetchAddress = fa; ResValid = rv; ResAddress = ra;
        ResTarget = rt; ResTaken = tk; ResHit = hit; ResBP = bp;
        #1;
        fw  = (mq.size() == QD) || (ms >= SM);
        iss = (mq.size() > 0) && (fw || !fr);
        rdy = mq.size() < QD;
        chk("we", BtbWe, iss);
        chk("grant", FetchGrant, fr && !iss);
        chk("en", BtbEn, iss || fr);
        chk("ready", ResReady, rdy);
        chk("index", BtbIndex, iss ? mq[0].idx : fa[7:2]);
        if (iss) begin
            chk("wr_tag", BtbWrTag, mq[0].tag);
            chk("wr_tgt", BtbWrTarget, mq[0].tgt);
            chk("wr_bp", BtbWrBP, mq[0].bp);
        end else
            chk("wr_idle", {BtbWrTag, BtbWrTarget, BtbWrBP}, 0);
        o_we = BtbWe; o_grant = FetchGrant; o_ready = ResReady; o_idx = BtbIndex; o_bp = BtbWrBP;
        if (BtbWe) wlog.push_back(BtbIndex);
        @(posedge Clk);
        if (Rst) begin
            mq.delete();
            ms = 0;
        end else begin
            if (iss) begin
                void'(mq.pop_front());
                ms = 0;
            end else if (mq.size() > 0 && fr)
                ms = ms < SM ? ms + 1 : SM;
            if (rv && rdy && (hit || tk)) begin
                e.idx = ra[7:2]; e.tag = ra[31:8]; e.tgt = rt; e.bp = nbp(hit, tk, bp);
                mq.push_back(e);
            end
            if (mq.size() == 0) ms = 0;
        end
        @(negedge Clk);
    endtask

    task automatic idle(input int n, input logic fr);
        repeat (n) cyc(fr, 32'h0000_0100, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        vec_t vt[7];
        int first;
        vt[0] = '{1, 1, 2'b11, 32'h0000_1008, 1, 2'b11, 6'h02};
        vt[1] = '{1, 0, 2'b00, 32'h0000_100C, 1, 2'b00, 6'h03};
        vt[2] = '{1, 1, 2'b01, 32'h0000_2010, 1, 2'b10, 6'h04};
        vt[3] = '{0, 1, 2'b00, 32'h0040_0104, 1, 2'b10, 6'h01};
        vt[4] = '{0, 0, 2'b11, 32'h0040_0108, 0, 2'b00, 6'h00};
        vt[5] = '{1, 0, 2'b10, 32'h0000_3014, 1, 2'b01, 6'h05};
        vt[6] = '{1, 1, 2'b10, 32'h0000_3018, 1, 2'b11, 6'h06};

        repeat (2) @(posedge Clk);
        @(negedge Clk);
        cyc(1, 32'h0000_00AC, 0, 0, 0, 0, 0, 0);
        chk("t1_grant", o_grant, 1);
        chk("t1_we", o_we, 0);
        chk("t1_ready", o_ready, 1);
        chk("t1_idx", o_idx, 6'h2B);
        Rst = 0;
        idle(2, 0);

        foreach (vt[i]) begin
            cyc(0, 0, 1, vt[i].pc, 32'hBEEF_0000 + i, vt[i].tk, vt[i].hit, vt[i].bp);
            cyc(0, 0, 0, 0, 0, 0, 0, 0);
            chk("t2_we", o_we, vt[i].exp_we);
            chk("t2_bp", o_bp, vt[i].exp_bp);
            chk("t2_idx", o_idx, vt[i].exp_idx);
            cyc(0, 0, 0, 0, 0, 0, 0, 0);
            chk("t2_quiet", o_we, 0);
        end

        first = 0;
        cyc(1, 32'h0000_0100, 1, 32'h0040_0104, 32'h1234_5678, 1, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            cyc(1, 32'h0000_0100, 0, 0, 0, 0, 0, 0);
            if (o_we && first == 0) first = k;
            chk("t3_grant", o_grant, k != 4);
        end
        chk("t3_latency", first, 4);

        wlog.delete();
        for (int i = 0; i < 5; i++) begin
            cyc(1, 32'h0000_0100, 1, 32'h0000_1000 + (i + 1) * 4, 32'hA000_0000 + i, 1, 0, 0);
            chk("t4_ready", o_ready, i < 4);
        end
        idle(20, 1);
        chk("t4_nwrites", wlog.size(), 4);
        for (int i = 0; i < wlog.size() && i < 4; i++) chk("t4_order", wlog[i], i + 1);

        wlog.delete();
        cyc(1, 32'h0000_0100, 1, 32'h0000_0028, 32'hC0, 1, 0, 0);
        cyc(1, 32'h0000_0100, 1, 32'h0000_002C, 32'hC1, 1, 0, 0);
        cyc(0, 32'h0000_0100, 1, 32'h0000_0030, 32'hC2, 1, 0, 0);
        chk("t5_deq_we", o_we, 1);
        chk("t5_deq_idx", o_idx, 10);
        cyc(0, 32'h0000_0100, 0, 0, 0, 0, 0, 0);
        chk("t5_b_idx", o_idx, 11);
        cyc(0, 32'h0000_0100, 0, 0, 0, 0, 0, 0);
        chk("t5_c_idx", o_idx, 12);
        cyc(0, 32'h0000_0100, 0, 0, 0, 0, 0, 0);
        chk("t5_empty", o_we, 0);
        wlog.delete();
        for (int i = 0; i < 10; i++)
            cyc(0, 0, 1, ((i * 7) % 64) * 4, i, 1, 1, 2'b01);
        idle(3, 0);
        chk("t5_nwrites", wlog.size(), 10);
        for (int i = 0; i < wlog.size() && i < 10; i++) chk("t5_wrap_order", wlog[i], (i * 7) % 64);

        wlog.delete();
        for (int i = 0; i < 3; i++) cyc(1, 32'h0000_0100, 1, 32'h0000_0200 + i * 4, i, 1, 0, 0);
        Rst = 1;
        cyc(1, 32'h0000_0100, 0, 0, 0, 0, 0, 0);
        Rst = 0;
        cyc(0, 32'h0000_0100, 0, 0, 0, 0, 0, 0);
        chk("t6_we", o_we, 0);
        chk("t6_ready", o_ready, 1);
        idle(6, 0);
        chk("t6_nwrites", wlog.size(), 0);

        for (int n = 0; n < 3000; n++) begin
            Rst = ($urandom_range(0, 199) == 0);
            cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1), $urandom, $urandom,
                $urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)));
        end
        Rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
